alu_share_arbiter: RTL and testbench

// - Shares the single combinational ALU among NUM_REQ requesters (e.g. integer pipe, branch-compare, AGU).
// - Round-robin arbitration; drives the ALU operand/opcode ports and captures ALUResult in one response register.
// - The response is tagged with the requester id and returned over a valid/ready handshake.
// - Sits between the issue logic and the alu instance; the ALU itself stays purely combinational.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 38 +++
 rtl/alu_share_arbiter.sv | 107 ++++++++++
 tb/tb_alu_share_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, opcode type and arbiter FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b1100;

  typedef logic [3:0] alu_op_t;

  // IDLE: response register empty; FULL: response register holds a result.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports: req (request vector), ptr (highest-priority index), en (allow any grant),
//        gnt (one-hot grant), gnt_idx (binary index of the grant, 0 when none).
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (en && !found && req[i] && (IW'(i) >= ptr)) begin
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
        found   = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (en && !found && req[i] && (IW'(i) < ptr)) begin
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin arbitration.
// Ports: clk/reset (async active-high); req_valid/req_ready/req_srca/req_srcb/req_op
//        per-requester request side; alu_srca/alu_srcb/alu_op/alu_result ALU side;
//        rsp_valid/rsp_ready/rsp_id/rsp_result single registered response.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = 32,
  parameter  int unsigned OPCODE_LENGTH = 4,
  parameter  int unsigned NUM_REQ       = 2,
  localparam int unsigned ID_W          = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_srca,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_srcb,
  input  logic [NUM_REQ*OPCODE_LENGTH-1:0]  req_op,
  output logic [DATA_WIDTH-1:0]             alu_srca,
  output logic [DATA_WIDTH-1:0]             alu_srcb,
  output logic [OPCODE_LENGTH-1:0]          alu_op,
  input  logic [DATA_WIDTH-1:0]             alu_result,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [ID_W-1:0]                   rsp_id,
  output logic [DATA_WIDTH-1:0]             rsp_result
);

  arb_state_t              state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic [NUM_REQ-1:0]      gnt_c;
  logic [ID_W-1:0]         gnt_idx_c;
  logic                    slot_free_c;
  logic                    arb_en_c;
  logic                    grant_c;

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

  // Pass-through slot: a response leaving this cycle frees room for a new one.
  assign slot_free_c = !rsp_valid || rsp_ready;
  assign arb_en_c    = slot_free_c && !reset;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (arb_en_c),
    .gnt     (gnt_c),
    .gnt_idx (gnt_idx_c)
  );

  assign grant_c   = |gnt_c;
  assign req_ready = gnt_c;

  // Operand mux; requester 0 is driven when nothing is granted (don't-care).
  always_comb begin
    alu_srca = req_srca[DATA_WIDTH-1:0];
    alu_srcb = req_srcb[DATA_WIDTH-1:0];
    alu_op   = req_op[OPCODE_LENGTH-1:0];
    for (int unsigned i = 1; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        alu_srca = req_srca[i*DATA_WIDTH +: DATA_WIDTH];
        alu_srcb = req_srcb[i*DATA_WIDTH +: DATA_WIDTH];
        alu_op   = req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
      end
    end
  end

  // Next state, response capture and round-robin pointer update.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    if (grant_c) begin
      state_d      = FULL;
      rsp_id_d     = gnt_idx_c;
      rsp_result_d = alu_result;
      rr_ptr_d     = (gnt_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + ID_W'(1);
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        FULL:    state_d = rsp_ready ? IDLE : FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: table of vectors plus hand sequences,
// with a scoreboard queue of expected responses.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;

  logic            clk;
  logic            reset;

  // Two-requester instance
  logic [1:0]      req_valid, req_ready;
  logic [2*DW-1:0] req_srca, req_srcb;
  logic [2*OW-1:0] req_op;
  logic [DW-1:0]   alu_srca, alu_srcb, alu_result;
  logic [OW-1:0]   alu_op;
  logic            rsp_valid, rsp_ready;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_result;

  // Three-requester instance for fairness
  logic [2:0]      req_valid3, req_ready3;
  logic [3*DW-1:0] req_srca3, req_srcb3;
  logic [3*OW-1:0] req_op3;
  logic [DW-1:0]   alu_srca3, alu_srcb3, alu_result3;
  logic [OW-1:0]   alu_op3;
  logic            rsp_valid3, rsp_ready3;
  logic [1:0]      rsp_id3;
  logic [DW-1:0]   rsp_result3;

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_XOR: return a ^ b;
      ALU_EQ:  return {31'b0, a == b};
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

  assign alu_result  = alu_fn(alu_srca, alu_srcb, alu_op);
  assign alu_result3 = alu_fn(alu_srca3, alu_srcb3, alu_op3);

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_op(req_op),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
  );

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_srca(req_srca3), .req_srcb(req_srcb3), .req_op(req_op3),
    .alu_srca(alu_srca3), .alu_srcb(alu_srcb3), .alu_op(alu_op3), .alu_result(alu_result3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_result(rsp_result3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    v;
    logic [DW-1:0] a0, b0;
    logic [OW-1:0] op0;
    logic [DW-1:0] a1, b1;
    logic [OW-1:0] op1;
    logic          rr;
    logic [1:0]    exp_rdy;
    logic [DW-1:0] exp_res;
  } vec_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] res;
  } exp_t;

  vec_t tbl[18];
  exp_t sb[$];
  logic m_valid;

  function automatic vec_t mk(input logic [1:0] v,
                              input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [OW-1:0] op0,
                              input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [OW-1:0] op1,
                              input logic rr, input logic [1:0] exp_rdy, input logic [DW-1:0] exp_res);
    vec_t t;
    t.v = v; t.a0 = a0; t.b0 = b0; t.op0 = op0;
    t.a1 = a1; t.b1 = b1; t.op1 = op1;
    t.rr = rr; t.exp_rdy = exp_rdy; t.exp_res = exp_res;
    return t;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge: drive, check before the next rising edge, advance.
  task automatic drive_cycle(input vec_t t, input string name);
    exp_t e;
    req_valid = t.v;
    req_srca  = {t.a1, t.a0};
    req_srcb  = {t.b1, t.b0};
    req_op    = {t.op1, t.op0};
    rsp_ready = t.rr;
    #2;
    check({name, ".rsp_valid"}, DW'(rsp_valid), DW'(m_valid));
    if (m_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL %s.scoreboard: got response 0x%0h expected none", name, rsp_result);
      end else begin
        e = sb[0];
        check({name, ".rsp_id"}, DW'(rsp_id), DW'(e.id));
        check({name, ".rsp_result"}, rsp_result, e.res);
        if (t.rr) void'(sb.pop_front());
      end
    end
    check({name, ".req_ready"}, DW'(req_ready), DW'(t.exp_rdy));
    if (t.exp_rdy != 2'b00) begin
      e.id  = t.exp_rdy[1];
      e.res = t.exp_res;
      sb.push_back(e);
      m_valid = 1'b1;
    end else if (t.rr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] exp_gnt3;
    m_valid    = 1'b0;
    reset      = 1'b1;
    req_valid  = 2'b11;
    req_srca   = {32'd1, 32'd2};
    req_srcb   = {32'd3, 32'd4};
    req_op     = {ALU_ADD, ALU_ADD};
    rsp_ready  = 1'b1;
    req_valid3 = 3'b000;
    req_srca3  = {32'd30, 32'd20, 32'd10};
    req_srcb3  = {32'd1, 32'd1, 32'd1};
    req_op3    = {ALU_ADD, ALU_ADD, ALU_ADD};
    rsp_ready3 = 1'b1;

    tbl[0]  = mk(2'b01, 5, 7, ALU_ADD, 0, 0, ALU_AND, 1'b1, 2'b01, 32'd12);
    tbl[1]  = mk(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 1'b1, 2'b00, 32'd0);
    tbl[2]  = mk(2'b10, 0, 0, ALU_AND, 32'hFF, 32'h0F, ALU_XOR, 1'b1, 2'b10, 32'hF0);
    tbl[3]  = mk(2'b11, 10, 3, ALU_SUB, 32'hF0, 32'h3C, ALU_AND, 1'b1, 2'b01, 32'd7);
    tbl[4]  = mk(2'b10, 10, 3, ALU_SUB, 32'hF0, 32'h3C, ALU_AND, 1'b1, 2'b10, 32'h30);
    tbl[5]  = mk(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 1'b1, 2'b00, 32'd0);
    tbl[6]  = mk(2'b01, 4, 4, ALU_EQ, 0, 0, ALU_AND, 1'b1, 2'b01, 32'd1);
    tbl[7]  = mk(2'b10, 0, 0, ALU_AND, 2, 9, ALU_SLT, 1'b0, 2'b00, 32'd0);
    tbl[8]  = mk(2'b10, 0, 0, ALU_AND, 2, 9, ALU_SLT, 1'b0, 2'b00, 32'd0);
    tbl[9]  = mk(2'b10, 0, 0, ALU_AND, 2, 9, ALU_SLT, 1'b0, 2'b00, 32'd0);
    tbl[10] = mk(2'b10, 0, 0, ALU_AND, 2, 9, ALU_SLT, 1'b1, 2'b10, 32'd1);
    tbl[11] = mk(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 1'b1, 2'b00, 32'd0);
    tbl[12] = mk(2'b01, 3, 4, 4'b0111, 0, 0, ALU_AND, 1'b1, 2'b01, 32'd0);
    tbl[13] = mk(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 1'b1, 2'b00, 32'd0);
    tbl[14] = mk(2'b11, 32'hFFFF_FFFF, 1, ALU_ADD, 32'hA0, 32'h05, ALU_OR, 1'b1, 2'b10, 32'hA5);
    tbl[15] = mk(2'b01, 32'hFFFF_FFFF, 1, ALU_ADD, 0, 0, ALU_AND, 1'b1, 2'b01, 32'd0);
    tbl[16] = mk(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 1'b1, 2'b00, 32'd0);
    tbl[17] = mk(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 1'b1, 2'b00, 32'd0);

    // Reset state with requests pending: nothing granted, response cleared.
    #1;
    check("reset.rsp_valid", DW'(rsp_valid), 32'd0);
    check("reset.rsp_id", DW'(rsp_id), 32'd0);
    check("reset.rsp_result", rsp_result, 32'd0);
    check("reset.req_ready", DW'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) drive_cycle(tbl[i], $sformatf("vec%0d", i));

    // Streaming: one accept and one response per cycle, no bubbles.
    for (int i = 0; i < 16; i++)
      drive_cycle(mk(2'b01, DW'(i), 1, ALU_ADD, 0, 0, ALU_AND, 1'b1, 2'b01, DW'(i + 1)),
                  $sformatf("stream%0d", i));
    drive_cycle(mk(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 1'b1, 2'b00, 32'd0), "stream_drain");
    check("stream.sb_empty", DW'(sb.size()), 32'd0);

    // Reset mid-transaction: held response discarded at once, pointer back to 0.
    drive_cycle(mk(2'b01, 1, 1, ALU_ADD, 0, 0, ALU_AND, 1'b0, 2'b01, 32'd2), "rst_pre");
    #2;
    reset = 1'b1;
    #1;
    check("midrst.rsp_valid", DW'(rsp_valid), 32'd0);
    check("midrst.rsp_id", DW'(rsp_id), 32'd0);
    check("midrst.rsp_result", rsp_result, 32'd0);
    check("midrst.req_ready", DW'(req_ready), 32'd0);
    sb.delete();
    m_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive_cycle(mk(2'b11, 10, 3, ALU_SUB, 32'hF0, 32'h3C, ALU_AND, 1'b1, 2'b01, 32'd7), "post_rst0");
    drive_cycle(mk(2'b10, 10, 3, ALU_SUB, 32'hF0, 32'h3C, ALU_AND, 1'b1, 2'b10, 32'h30), "post_rst1");
    drive_cycle(mk(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 1'b1, 2'b00, 32'd0), "post_rst2");
    drive_cycle(mk(2'b00, 0, 0, ALU_AND, 0, 0, ALU_AND, 1'b1, 2'b00, 32'd0), "post_rst3");

    // Fairness on three requesters, all continuously valid.
    req_valid3 = 3'b111;
    for (int k = 0; k < 9; k++) begin
      #2;
      exp_gnt3 = 3'(1 << (k % 3));
      check($sformatf("fair%0d.req_ready", k), DW'(req_ready3), DW'(exp_gnt3));
      if (k > 0) begin
        check($sformatf("fair%0d.rsp_id", k), DW'(rsp_id3), DW'((k - 1) % 3));
        check($sformatf("fair%0d.rsp_result", k), rsp_result3, DW'(10 * ((k - 1) % 3 + 1) + 1));
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid3 = 3'b000;
    #2;
    check("fair_last.rsp_valid", DW'(rsp_valid3), 32'd1);
    check("fair_last.rsp_id", DW'(rsp_id3), 32'd2);
    check("fair_last.rsp_result", rsp_result3, 32'd31);
    @(posedge clk);
    #1;
    check("fair_drain.rsp_valid", DW'(rsp_valid3), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
